// File: rtl/sc_gameflow_pkg.sv
// Shared state codes and default sizing for the Frogger game-flow sequencer,
// so the display and speed-select blocks decode the same values.
package sc_gameflow_pkg;

    localparam logic [2:0] STATE_IDLE       = 3'd0;
    localparam logic [2:0] STATE_CLEAR      = 3'd1;
    localparam logic [2:0] STATE_WAIT_START = 3'd2;
    localparam logic [2:0] STATE_PLAY       = 3'd3;
    localparam logic [2:0] STATE_HIT        = 3'd4;
    localparam logic [2:0] STATE_GOAL       = 3'd5;
    localparam logic [2:0] STATE_RESPAWN    = 3'd6;
    localparam logic [2:0] STATE_END        = 3'd7;

    typedef enum logic [2:0] {
        StIdle      = STATE_IDLE,
        StClear     = STATE_CLEAR,
        StWaitStart = STATE_WAIT_START,
        StPlay      = STATE_PLAY,
        StHit       = STATE_HIT,
        StGoal      = STATE_GOAL,
        StRespawn   = STATE_RESPAWN,
        StEnd       = STATE_END
    } gameState_t;

    localparam int unsigned GF_LIVES_INIT   = 3;
    localparam int unsigned GF_LIVES_MAX    = 7;
    localparam int unsigned GF_LIVES_W      = 3;
    localparam int unsigned GF_LEVELS       = 4;
    localparam int unsigned GF_LEVEL_W      = 2;
    localparam int unsigned GF_CLEAR_CYCLES = 4;

    // Width of a down-counter that must hold cycles-1.
    function automatic int unsigned clearCntWidth(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sc_gameflow_button_sync.sv
// Two-flop synchronizer plus falling-edge one-shot for an active-low key.
// All flops reset to 1 (key released), so reset never fakes a press.
module sc_gameflow_button_sync (
    input  logic SC_STATEMACHINEGENERAL_CLOCK_50,
    input  logic SC_STATEMACHINEGENERAL_RESET_InHigh,
    input  logic SC_BUTTONSYNC_button_InLow,
    output logic SC_BUTTONSYNC_press_OutHigh
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
        if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= SC_BUTTONSYNC_button_InLow;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // High for the single cycle where the synchronized key goes 1 -> 0.
    assign SC_BUTTONSYNC_press_OutHigh = prev_q & ~sync_q;

endmodule

// File: rtl/sc_gameflow_controller.sv
// Round and lives sequencer for Frogger: clear, wait-for-start, play, hit, goal,
// respawn and end phases. Define FROGGER_BONUS_LIFE_EN to award a life per level-up.
module sc_gameflow_controller
    import sc_gameflow_pkg::*;
#(
    parameter int unsigned LIVES_INIT   = GF_LIVES_INIT,
    parameter int unsigned LIVES_MAX    = GF_LIVES_MAX,
    parameter int unsigned LIVES_W      = GF_LIVES_W,
    parameter int unsigned LEVELS       = GF_LEVELS,
    parameter int unsigned LEVEL_W      = GF_LEVEL_W,
    parameter int unsigned CLEAR_CYCLES = GF_CLEAR_CYCLES
) (
    input  logic               SC_STATEMACHINEGENERAL_CLOCK_50,
    input  logic               SC_STATEMACHINEGENERAL_RESET_InHigh,
    input  logic               SC_GAMEFLOW_startButton_InLow,
    input  logic               SC_GAMEFLOW_frogHit_InLow,
    input  logic               SC_GAMEFLOW_frogGoal_InLow,
    output logic               SC_GAMEFLOW_clear_OutLow,
    output logic               SC_GAMEFLOW_respawn_OutLow,
    output logic               SC_GAMEFLOW_playing_OutHigh,
    output logic               SC_GAMEFLOW_gameOver_OutHigh,
    output logic               SC_GAMEFLOW_win_OutHigh,
    output logic [LIVES_W-1:0] SC_GAMEFLOW_lives_OutBus,
    output logic [LEVEL_W-1:0] SC_GAMEFLOW_level_OutBus,
    output logic [2:0]         SC_GAMEFLOW_state_OutBus
);

    localparam int unsigned CLR_W = clearCntWidth(CLEAR_CYCLES);
    localparam logic [CLR_W-1:0]   CLR_LOAD   = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
    localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(LEVELS - 1);

    if (CLEAR_CYCLES < 1 || LEVELS < 1 || LEVELS > (2 ** LEVEL_W) ||
        LIVES_MAX >= (2 ** LIVES_W) || LIVES_INIT >= (2 ** LIVES_W)) begin : gBadParams
        $error("sc_gameflow_controller: inconsistent parameters");
    end

    gameState_t         state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               gameOver_q, gameOver_d;
    logic               win_q, win_d;
    logic [CLR_W-1:0]   clrCnt_q, clrCnt_d;
    logic               startEvent;

    sc_gameflow_button_sync uStartSync (
        .SC_STATEMACHINEGENERAL_CLOCK_50    (SC_STATEMACHINEGENERAL_CLOCK_50),
        .SC_STATEMACHINEGENERAL_RESET_InHigh(SC_STATEMACHINEGENERAL_RESET_InHigh),
        .SC_BUTTONSYNC_button_InLow         (SC_GAMEFLOW_startButton_InLow),
        .SC_BUTTONSYNC_press_OutHigh        (startEvent)
    );

    always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
        if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
            state_q    <= StIdle;
            lives_q    <= LIVES_LOAD;
            level_q    <= '0;
            gameOver_q <= 1'b0;
            win_q      <= 1'b0;
            clrCnt_q   <= CLR_LOAD;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            gameOver_q <= gameOver_d;
            win_q      <= win_d;
            clrCnt_q   <= clrCnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        gameOver_d = gameOver_q;
        win_d      = win_q;
        // Counter idles at its load value so every CLEAR visit is full length.
        clrCnt_d   = CLR_LOAD;

        unique case (state_q)
            StIdle: state_d = StClear;
            StClear: begin
                if (clrCnt_q == '0) begin
                    state_d = StWaitStart;
                end else begin
                    clrCnt_d = clrCnt_q - CLR_W'(1);
                end
            end
            StWaitStart: begin
                if (startEvent) state_d = StPlay;
            end
            StPlay: begin
                if (!SC_GAMEFLOW_frogHit_InLow) begin
                    state_d = StHit;
                end else if (!SC_GAMEFLOW_frogGoal_InLow) begin
                    state_d = StGoal;
                end
            end
            StHit: begin
                if (lives_q <= LIVES_W'(1)) begin
                    lives_d    = '0;
                    gameOver_d = 1'b1;
                    state_d    = StEnd;
                end else begin
                    lives_d = lives_q - LIVES_W'(1);
                    state_d = StRespawn;
                end
            end
            StGoal: begin
                if (level_q == LEVEL_LAST) begin
                    win_d   = 1'b1;
                    state_d = StEnd;
                end else begin
                    level_d = level_q + LEVEL_W'(1);
`ifdef FROGGER_BONUS_LIFE_EN
                    if (lives_q < LIVES_W'(LIVES_MAX)) begin
                        lives_d = lives_q + LIVES_W'(1);
                    end else begin
                        lives_d = LIVES_W'(LIVES_MAX);
                    end
`else
                    lives_d = lives_q;
`endif
                    state_d = StRespawn;
                end
            end
            StRespawn: begin
                // Datapath must drop both flags before play resumes.
                if (SC_GAMEFLOW_frogHit_InLow && SC_GAMEFLOW_frogGoal_InLow) state_d = StPlay;
            end
            StEnd: begin
                if (startEvent) state_d = StClear;
            end
        endcase

        // New game: counters are reloaded on the way into CLEAR.
        if (state_d == StClear) begin
            lives_d    = LIVES_LOAD;
            level_d    = '0;
            gameOver_d = 1'b0;
            win_d      = 1'b0;
        end
    end

    assign SC_GAMEFLOW_clear_OutLow     = !(state_q == StIdle || state_q == StClear);
    assign SC_GAMEFLOW_respawn_OutLow   = (state_q != StRespawn);
    assign SC_GAMEFLOW_playing_OutHigh  = (state_q == StPlay);
    assign SC_GAMEFLOW_gameOver_OutHigh = gameOver_q;
    assign SC_GAMEFLOW_win_OutHigh      = win_q;
    assign SC_GAMEFLOW_lives_OutBus     = lives_q;
    assign SC_GAMEFLOW_level_OutBus     = level_q;
    assign SC_GAMEFLOW_state_OutBus     = state_q;

endmodule

// File: tb/tb_sc_gameflow_controller.sv
// Self-checking bench for sc_gameflow_controller: scripted vector table plus
// randomized play checked cycle by cycle against a behavioural game model.
module tb_sc_gameflow_controller;

`ifdef FROGGER_BONUS_LIFE_EN
    localparam int BONUS = 1;
    localparam int LI    = 6;
`else
    localparam int BONUS = 0;
    localparam int LI    = 3;
`endif
    localparam int LMAX   = 7;
    localparam int LEVELS = 4;
    localparam int CC     = 4;

    logic       clk;
    logic       rst;
    logic       pin;
    logic       hit;
    logic       goal;
    logic       clearO, respawnO, playingO, overO, winO;
    logic [2:0] livesO;
    logic [1:0] levelO;
    logic [2:0] stateO;
    logic [12:0] dutVec;

    sc_gameflow_controller #(
        .LIVES_INIT  (LI),
        .LIVES_MAX   (LMAX),
        .LIVES_W     (3),
        .LEVELS      (LEVELS),
        .LEVEL_W     (2),
        .CLEAR_CYCLES(CC)
    ) dut (
        .SC_STATEMACHINEGENERAL_CLOCK_50    (clk),
        .SC_STATEMACHINEGENERAL_RESET_InHigh(rst),
        .SC_GAMEFLOW_startButton_InLow      (pin),
        .SC_GAMEFLOW_frogHit_InLow          (hit),
        .SC_GAMEFLOW_frogGoal_InLow         (goal),
        .SC_GAMEFLOW_clear_OutLow           (clearO),
        .SC_GAMEFLOW_respawn_OutLow         (respawnO),
        .SC_GAMEFLOW_playing_OutHigh        (playingO),
        .SC_GAMEFLOW_gameOver_OutHigh       (overO),
        .SC_GAMEFLOW_win_OutHigh            (winO),
        .SC_GAMEFLOW_lives_OutBus           (livesO),
        .SC_GAMEFLOW_level_OutBus           (levelO),
        .SC_GAMEFLOW_state_OutBus           (stateO)
    );

    assign dutVec = {clearO, respawnO, playingO, overO, winO, livesO, levelO, stateO};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output vector implied by a game phase code and the counters.
    function automatic logic [12:0] expVec(input int st, input int lv, input int lev,
                                           input bit ov, input bit wn);
        logic [2:0] s3;
        logic [2:0] l3;
        logic [1:0] v2;
        s3 = st[2:0];
        l3 = lv[2:0];
        v2 = lev[1:0];
        return {(st != 0 && st != 1), (st != 6), (st == 3), ov, wn, l3, v2, s3};
    endfunction

    // Behavioural model: phase code, counters, and the last three pin samples.
    int mState, mLives, mLevel, mClr;
    bit mOver, mWin;
    bit h1, h2, h3;

    function automatic void mReset();
        mState = 0; mLives = LI; mLevel = 0; mClr = 0;
        mOver = 0; mWin = 0;
        h1 = 1; h2 = 1; h3 = 1;
    endfunction

    function automatic int bonusUp(input int lv);
        if (BONUS == 0) return lv;
        return (lv + 1 > LMAX) ? LMAX : lv + 1;
    endfunction

    function automatic void mStep();
        // A press counts when the pin read high three edges ago and low two edges ago.
        bit ev;
        ev = (h2 == 0) && (h3 == 1);
        case (mState)
            0: begin mState = 1; mClr = 0; end
            1: begin mClr++; if (mClr >= CC) mState = 2; end
            2: if (ev) mState = 3;
            3: if (!hit) mState = 4; else if (!goal) mState = 5;
            4: if (mLives <= 1) begin
                   mLives = 0; mOver = 1; mState = 7;
               end else begin
                   mLives--; mState = 6;
               end
            5: if (mLevel == LEVELS - 1) begin
                   mWin = 1; mState = 7;
               end else begin
                   mLevel++; mLives = bonusUp(mLives); mState = 6;
               end
            6: if (hit && goal) mState = 3;
            7: if (ev) begin
                   mState = 1; mClr = 0; mLives = LI; mLevel = 0; mOver = 0; mWin = 0;
               end
            default: mState = 0;
        endcase
        h3 = h2; h2 = h1; h1 = pin;
    endfunction

    task automatic tick(input bit cmp);
        @(posedge clk);
        if (rst) mReset(); else mStep();
        #1;
        if (cmp) check("model_cycle", dutVec, expVec(mState, mLives, mLevel, mOver, mWin));
    endtask

    typedef struct {
        bit    pin;
        bit    hit;
        bit    goal;
        int    cyc;
        int    st;
        int    lv;
        int    lev;
        bit    ov;
        bit    wn;
        string name;
    } row_t;

    row_t rows[$];

    function automatic void addRow(input bit p, input bit h, input bit g, input int c,
                                   input int st, input int lv, input int lev,
                                   input bit ov, input bit wn, input string nm);
        row_t r;
        r.pin = p; r.hit = h; r.goal = g; r.cyc = c;
        r.st = st; r.lv = lv; r.lev = lev; r.ov = ov; r.wn = wn; r.name = nm;
        rows.push_back(r);
    endfunction

    initial begin
        int clrCycles;
        int guard;
        int e1, e2, e3;

        // Start press latency, hold and a press during play.
        addRow(0, 1, 1, 2,  2, LI, 0, 0, 0, "start_latency_pre");
        addRow(0, 1, 1, 1,  3, LI, 0, 0, 0, "start_latency_3clk");
        addRow(0, 1, 1, 97, 3, LI, 0, 0, 0, "start_held_no_repeat");
        addRow(1, 1, 1, 5,  3, LI, 0, 0, 0, "start_release");
        addRow(0, 1, 1, 5,  3, LI, 0, 0, 0, "press_in_play_ignored");
        addRow(1, 1, 1, 5,  3, LI, 0, 0, 0, "press_in_play_release");
        // Hits down to the last life, each held through RESPAWN.
        for (int k = LI; k > 1; k--) begin
            addRow(1, 0, 1, 1, 4, k,     0, 0, 0, "hit_enter");
            addRow(1, 0, 1, 3, 6, k - 1, 0, 0, 0, "respawn_holds_on_hit");
            addRow(1, 1, 1, 1, 3, k - 1, 0, 0, 0, "respawn_release");
        end
        addRow(1, 0, 1, 1, 4, 1, 0, 1'b0, 0, "last_hit_enter");
        addRow(1, 0, 1, 1, 7, 0, 0, 1'b1, 0, "game_over");
        addRow(1, 1, 1, 3, 7, 0, 0, 1'b1, 0, "game_over_hold");
        // Restart from END, with a fresh press landing inside CLEAR.
        addRow(0, 1, 1, 2, 7, 0,  0, 1, 0, "end_start_pre");
        addRow(0, 1, 1, 1, 1, LI, 0, 0, 0, "end_start_clear");
        addRow(1, 1, 1, 1, 1, LI, 0, 0, 0, "clear_release");
        addRow(0, 1, 1, 3, 2, LI, 0, 0, 0, "clear_done");
        addRow(0, 1, 1, 5, 2, LI, 0, 0, 0, "press_in_clear_ignored");
        addRow(1, 1, 1, 2, 2, LI, 0, 0, 0, "wait_release");
        addRow(0, 1, 1, 3, 3, LI, 0, 0, 0, "restart_play");
        // Goals, a simultaneous hit+goal, then the winning goal.
        e1 = bonusUp(LI);
        e2 = bonusUp(e1 - 1);
        e3 = bonusUp(e2);
        addRow(1, 1, 0, 1,  5, LI,     0, 0, 0, "goal_enter");
        addRow(1, 1, 0, 1,  6, e1,     1, 0, 0, "goal_level1");
        addRow(1, 1, 0, 10, 6, e1,     1, 0, 0, "respawn_waits_goal");
        addRow(1, 1, 1, 1,  3, e1,     1, 0, 0, "goal_release");
        addRow(1, 0, 0, 1,  4, e1,     1, 0, 0, "hit_goal_same_cycle");
        addRow(1, 0, 0, 1,  6, e1 - 1, 1, 0, 0, "hit_priority");
        addRow(1, 1, 1, 1,  3, e1 - 1, 1, 0, 0, "hit_goal_release");
        addRow(1, 1, 0, 2,  6, e2,     2, 0, 0, "goal_level2");
        addRow(1, 1, 1, 1,  3, e2,     2, 0, 0, "goal2_release");
        addRow(1, 1, 0, 2,  6, e3,     3, 0, 0, "goal_level3");
        addRow(1, 1, 1, 1,  3, e3,     3, 0, 0, "goal3_release");
        addRow(1, 1, 0, 1,  5, e3,     3, 0, 0, "final_goal_enter");
        addRow(1, 1, 0, 1,  7, e3,     3, 0, 1, "win");
        addRow(1, 1, 1, 3,  7, e3,     3, 0, 1, "win_hold");

        rst = 1'b1; pin = 1'b1; hit = 1'b1; goal = 1'b1;
        mReset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_values", dutVec, expVec(0, LI, 0, 0, 0));
        rst = 1'b0;

        // Reset release: one IDLE cycle, then CLEAR for CC cycles.
        clrCycles = 0;
        guard = 0;
        tick(1);
        while (stateO != 3'd2 && guard < 20) begin
            if (stateO == 3'd1 && clearO == 1'b0) clrCycles++;
            tick(1);
            guard++;
        end
        check("wait_start_reached", {29'd0, stateO}, 32'd2);
        check("clear_cycles", clrCycles, CC);
        check("after_clear", dutVec, expVec(2, LI, 0, 0, 0));

        foreach (rows[i]) begin
            pin = rows[i].pin; hit = rows[i].hit; goal = rows[i].goal;
            repeat (rows[i].cyc) tick(1);
            check(rows[i].name, dutVec,
                  expVec(rows[i].st, rows[i].lv, rows[i].lev, rows[i].ov, rows[i].wn));
        end

        // Asynchronous reset in the middle of RESPAWN.
        pin = 1'b1; hit = 1'b1; goal = 1'b1;
        repeat (2) tick(1);
        pin = 1'b0;
        repeat (3) tick(1);
        pin = 1'b1;
        guard = 0;
        while (stateO != 3'd2 && guard < 20) begin
            tick(1);
            guard++;
        end
        pin = 1'b0;
        repeat (3) tick(1);
        goal = 1'b0;
        repeat (2) tick(1);
        check("in_respawn_before_reset", {29'd0, stateO}, 32'd6);
        #3;
        rst = 1'b1;
        mReset();
        #1;
        check("async_reset_no_clock", dutVec, expVec(0, LI, 0, 0, 0));
        tick(1);
        rst = 1'b0;
        pin = 1'b1; goal = 1'b1;

        // Randomized play against the model, with occasional mid-cycle resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 5) == 0) pin = ~pin;
            hit  = ($urandom_range(0, 9) != 0);
            goal = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 799) == 0) begin
                #2;
                rst = 1'b1;
                mReset();
                #1;
                check("rand_async_reset", dutVec, expVec(0, LI, 0, 0, 0));
                tick(1);
                rst = 1'b0;
            end else begin
                tick(1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/sc_gameflow_controller.md
Name: sc_gameflow_controller

Overview:
Top-level round and lives sequencer for the Frogger game. It owns the lives and level counters and debounces the start button into a single event. It sequences clear, wait-for-start, play, hit, level-up, game-over and win phases. Outputs drive the background and frog datapaths (clear, respawn), the speed selector (level) and the score/lives display.

Parameters:
LIVES_INIT, 3, lives loaded on every new game
LIVES_MAX, 7, saturation ceiling for lives (optional feature only); must be < 2^LIVES_W
LIVES_W, 3, lives counter width
LEVELS, 4, number of levels; goal reached on level LEVELS-1 gives WIN
LEVEL_W, 2, level counter width; LEVELS <= 2^LEVEL_W
CLEAR_CYCLES, 4, cycles clear_OutLow is held low per CLEAR visit (>=1)

Ports:
SC_STATEMACHINEGENERAL_CLOCK_50  in  1  system clock, 50 MHz
SC_STATEMACHINEGENERAL_RESET_InHigh  in  1  reset; asynchronous, active-high
SC_GAMEFLOW_startButton_InLow  in  1  start key, asynchronous, active-low
SC_GAMEFLOW_frogHit_InLow  in  1  collision/drown level from the frog datapath, active-low
SC_GAMEFLOW_frogGoal_InLow  in  1  frog reached top row, active-low
SC_GAMEFLOW_clear_OutLow  out  1  datapath clear, active-low
SC_GAMEFLOW_respawn_OutLow  out  1  frog reposition request, active-low
SC_GAMEFLOW_playing_OutHigh  out  1  play phase active
SC_GAMEFLOW_gameOver_OutHigh  out  1  lives exhausted
SC_GAMEFLOW_win_OutHigh  out  1  final level cleared
SC_GAMEFLOW_lives_OutBus  out  LIVES_W  current lives
SC_GAMEFLOW_level_OutBus  out  LEVEL_W  current level, 0-based
SC_GAMEFLOW_state_OutBus  out  3  state code, debug

Behaviour:
- Clock and reset: SC_STATEMACHINEGENERAL_RESET_InHigh is an asynchronous, active-high reset. The clock is SC_STATEMACHINEGENERAL_CLOCK_50. All outputs are registered or decoded from registered state only.
- Reset values:
  - state = IDLE
  - lives = LIVES_INIT, level = 0
  - clear_OutLow = 0, respawn_OutLow = 1
  - playing, gameOver, win = 0
  - start synchronizer flops = 1
- Start event:
  - 2-flop synchronizer, then falling-edge detect (previous = 1, current = 0).
  - One event per press; holding the key produces no repeat.
  - Start latency: 3 clocks from pin to event.
- State codes: IDLE=0, CLEAR=1, WAIT_START=2, PLAY=3, HIT=4, GOAL=5, RESPAWN=6, END=7. END covers both game-over and win, distinguished by flag registers.
- IDLE: unconditionally goes to CLEAR next cycle.
- CLEAR:
  - clear_OutLow = 0 for exactly CLEAR_CYCLES cycles (internal down-counter).
  - lives = LIVES_INIT, level = 0, gameOver/win flags = 0.
  - Then goes to WAIT_START.
  - A start event during CLEAR is ignored.
- WAIT_START:
  - clear_OutLow = 1.
  - On start event, goes to PLAY.
- PLAY:
  - playing_OutHigh = 1.
  - If frogHit_InLow = 0, go to HIT. Else if frogGoal_InLow = 0, go to GOAL.
  - Hit has priority when both are asserted in the same cycle.
  - Start events are ignored.
- HIT (1 cycle):
  - If lives == 1: lives becomes 0, set gameOver, go to END.
  - Otherwise: lives decrements, go to RESPAWN.
  - Lives never wraps below 0.
- GOAL (1 cycle):
  - If level == LEVELS-1: set win, go to END; level holds.
  - Otherwise: level increments, go to RESPAWN.
- RESPAWN:
  - respawn_OutLow = 0 while in this state.
  - Stays until both frogHit_InLow and frogGoal_InLow read 1 (handshake: the datapath must release its flags). Then goes to PLAY.
  - Minimum dwell: 1 cycle.
- END:
  - gameOver_OutHigh or win_OutHigh held at 1; lives and level frozen.
  - On start event, go to CLEAR, which starts a new game.
- Reset mid-operation: immediate return to the reset values, from any state.

Optional Feature:
FROGGER_BONUS_LIFE_EN
- Defined: on a non-final GOAL, lives also increments, saturating at LIVES_MAX. On the final-level GOAL, lives is unchanged.
- Undefined: lives changes only by HIT decrement and CLEAR reload.

Decomposition:
- Shared package: state code localparams (IDLE..END), LIVES_INIT, LEVELS, and the default widths, so the display and speed blocks decode the same values.
- One natural sub-module, sc_gameflow_button_sync: 2-flop synchronizer plus falling-edge one-shot, reset to 1. It is reusable for other keys.
- The CLEAR counter and the lives/level counters stay inline.

Test Plan:
1. Reset release, no input: clear_OutLow low for exactly 4 cycles starting 1 cycle after IDLE; then state=2, lives=3, level=0.
2. Start press held 100 cycles in WAIT_START: exactly one transition to PLAY, 3 clocks after the pin falls; playing=1. A second press during PLAY causes no change.
3. Three hits, each released during RESPAWN: lives goes 3→2→1, respawn low until release. The third hit gives lives=0, gameOver=1, state=7. Start gives CLEAR, then lives=3.
4. frogHit and frogGoal asserted in the same cycle at level 1, lives 3: HIT path taken, lives=2, level stays 1.
5. Four goals (LEVELS=4): level 0→1→2→3, then win=1 with level held at 3. RESPAWN waits while frogGoal_InLow stays low for 10 cycles.
6. FROGGER_BONUS_LIFE_EN with LIVES_INIT=6, LIVES_MAX=7: two goals give lives 7 then 7 (saturated). Asynchronous reset asserted mid-RESPAWN: all outputs return to reset values immediately, without waiting for a clock edge.
